// File: rtl/pipe_pkg.sv
// Shared definitions for the multiply stage: word width, operand field
// layout inside the incoming word, and the stage FSM encoding.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = DATA_W / 2;

    // Operand fields inside one input word: b in the upper half, a in the lower.
    localparam int A_LSB  = 0;
    localparam int B_LSB  = OP_W;

    // Iteration counter width; covers 0..ITER-1 for ITER up to 32.
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier datapath. One partial product is folded in
// per step; the controller decides when to load and when to step.
// prod_nxt_o is the accumulator value after the current step, so the
// controller can capture the final product on the same edge as the last step.
module shift_add_mul
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ITER   = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] prod_nxt_o,
    output logic              last_o
);

    localparam int OPW = DATA_W / 2;

    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] partial;

    // Partial product for this step: b shifted by the bit position of a[0].
    always_comb begin
        partial = '0;
        if (a_q[0]) begin
            partial = DATA_W'(b_q) << cnt_q;
        end
    end

    assign prod_nxt_o = prod_q + partial;
    assign last_o     = (cnt_q == CNT_W'(ITER - 1));

    // Next-state: load restarts the operation, step consumes one bit of a.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            a_d    = word_i[A_LSB +: OPW];
            b_d    = word_i[B_LSB +: OPW];
            prod_d = '0;
            cnt_d  = '0;
        end else if (step_i) begin
            a_d    = a_q >> 1;
            prod_d = prod_nxt_o;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/iter_mul_stage.sv
// Multiply stage behind the stall buffer: takes one packed operand word per
// in_valid pulse, multiplies the two 16-bit halves iteratively and presents
// a registered result. A one-entry skid holds the word the buffer can still
// emit after stall_req rises; any further word is dropped and flagged in ovf.
//
//   state | meaning
//   IDLE  | no operation in progress, ready for a word
//   BUSY  | shift-add iterations running, ITER cycles
//   DONE  | result on out_data/out_valid, waiting for out_stall=0
module iter_mul_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ITER   = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              out_stall,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              stall_req,
    output logic              ovf
);

    mul_state_t        state_q, state_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;

    logic              park;
    logic              mul_load;
    logic              mul_step;
    logic              mul_last;
    logic [DATA_W-1:0] mul_word;
    logic [DATA_W-1:0] mul_prod_nxt;

    shift_add_mul #(
        .DATA_W (DATA_W),
        .ITER   (ITER)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .load_i     (mul_load),
        .step_i     (mul_step),
        .word_i     (mul_word),
        .prod_nxt_o (mul_prod_nxt),
        .last_o     (mul_last)
    );

    // Next state, datapath control, skid capture and result register update.
    always_comb begin
        state_d      = state_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        ovf_d        = ovf_q;
        mul_load     = 1'b0;
        mul_step     = 1'b0;
        mul_word     = in_data;
        park         = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mul_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Never frozen by out_stall; the result register absorbs it.
                mul_step = 1'b1;
                park     = 1'b1;
                if (mul_last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = mul_prod_nxt;
                end
            end
            DONE: begin
                if (out_stall) begin
                    park = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                    if (skid_valid_q) begin
                        // Skid word starts now; a word arriving this cycle
                        // takes its place in the freed skid.
                        mul_load     = 1'b1;
                        mul_word     = skid_data_q;
                        state_d      = BUSY;
                        skid_valid_d = in_valid;
                        if (in_valid) begin
                            skid_data_d = in_data;
                        end
                    end else if (in_valid) begin
                        mul_load = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (park && in_valid) begin
            if (skid_valid_q) begin
                ovf_d = 1'b1;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end

        // Flush discards everything in flight but keeps the overflow record.
        if (flush) begin
            state_d      = IDLE;
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            ovf_d        = ovf_q;
            mul_load     = 1'b0;
            mul_step     = 1'b0;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    // Registered terms only, so there is no path from in_valid.
    assign stall_req = (state_q != IDLE) || skid_valid_q;

endmodule

// File: doc/iter_mul_stage.md
# iter_mul_stage

Downstream consumer of the stall-buffer stage. It accepts one 32-bit word per handshake from the buffer's `outputs`/`out_valid` pair and treats it as two packed 16-bit unsigned operands. It computes their 32-bit product with an iterative shift-add datapath, presenting one result per operation. While busy it raises `stall_req` to stall management. A one-entry skid register absorbs the word the buffer may still emit in the cycle after `stall_req` rises.

## Interface
- `DATA_W`, 32, input/output word width; operands are `DATA_W/2` bits each.
- `ITER`, 16, shift-add iterations per operation; must equal `DATA_W/2`.
- `clk  in  1  clock`
- `reset  in  1  asynchronous, active-high`
- `in_data  in  DATA_W  operand word: b = in_data[31:16], a = in_data[15:0]`
- `in_valid  in  1  in_data valid this cycle (single-cycle pulses, no ready)`
- `flush  in  1  synchronous pipeline flush`
- `out_stall  in  1  downstream not accepting; hold result`
- `out_data  out  DATA_W  product a*b`
- `out_valid  out  1  out_data valid`
- `stall_req  out  1  to stall management; stage cannot take a new word`
- `ovf  out  1  sticky: a word was dropped because the skid was already full`

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - BUSY: iterating; the 5-bit counter `cnt` runs 0..ITER-1.
  - DONE: result presented.
- IDLE, `in_valid`=1:
  - Load `a`, `b` from `in_data`, clear the product accumulator, set `cnt`=0.
  - Go to BUSY.
- BUSY, each cycle:
  - If `a[0]`, then `prod += b << cnt`.
  - Then `a >>= 1` and `cnt++`.
  - When `cnt`=ITER-1, go to DONE after that update.
  - BUSY always advances; `out_stall` does not freeze it.
- DONE:
  - `out_data` = product and `out_valid`=1, both registered.
  - While `out_stall`=1: stay in DONE and hold `out_data`/`out_valid` stable.
  - When `out_stall`=0, the result is consumed this cycle. Next state:
    - skid full: BUSY, loaded from the skid; skid cleared.
    - else, `in_valid`=1 this cycle: BUSY, loaded from `in_data`.
    - else: IDLE.
- Skid capture:
  - Applies to `in_valid`=1 when the state is not IDLE and the word is not consumed directly by the DONE exit.
  - Skid empty: capture the word.
  - Skid full: drop the word and set `ovf`=1.
- `stall_req` = (state != IDLE) OR `skid_valid`. It is driven only from registers, with no combinational path from `in_valid`.
- Arithmetic is unsigned: 16x16 to 32 bits, no overflow possible, no truncation.
- `flush`:
  - Highest priority after reset.
  - Next cycle: IDLE, skid empty, `out_valid`=0, `out_data`=0.
  - `in_valid` in the flush cycle is ignored.
  - `ovf` is not cleared by flush.
- `reset`, asserted at any time including mid-operation:
  - Immediately: all state to IDLE; `out_data`=0, `out_valid`=0, `stall_req`=0, `ovf`=0; skid empty.

## Timing
- Word accepted in IDLE at edge T:
  - `stall_req`=1 from T+1.
  - BUSY occupies T+1..T+16.
  - `out_valid`=1 from T+17 (latency 17 cycles with `out_stall`=0).
- `out_valid` is a one-cycle pulse per result when `out_stall`=0. Otherwise it is held until the first cycle with `out_stall`=0.
- Back-to-back from skid: the next BUSY starts the cycle after DONE. Throughput is 1 result per 17 cycles.
- `stall_req` deasserts the cycle after a DONE exit to IDLE.
- The buffer's registered `out_valid` lags stall by at most one cycle. The skid covers exactly that one word; a second word sets `ovf`.

## Structure
- Shared package `pipe_pkg` holds:
  - `DATA_W` default constant.
  - `mul_state_t` enum {IDLE, BUSY, DONE}.
  - Operand-field slice constants.
- Natural sub-module: `shift_add_mul`, the datapath with `a`/`b`/`prod`/`cnt` registers and load/step/done signals. The FSM, skid and flush/stall logic live in `iter_mul_stage`.

## Test plan
- Single operand `in_data`=0x0003_0005 in IDLE:
  - `out_valid` at T+17 with `out_data`=0x0000_000F.
  - `stall_req` high T+1..T+17.
- Max operands 0xFFFF_FFFF → `out_data`=0xFFFE_0001. Zero operand 0x1234_0000 → 0x0000_0000.
- Second word 0x0002_0002 pulsed at T+1 while busy:
  - Captured in the skid.
  - First result at T+17; `out_data`=0x0000_0004 at T+34.
  - `ovf`=0.
- Three words at T, T+1, T+2 → third word dropped, `ovf`=1 sticky; flush keeps `ovf`=1, reset clears it.
- `out_stall`=1 for 5 cycles starting when DONE is entered → `out_data`/`out_valid` stable for 5 cycles, consumed on cycle 6.
- `flush` at T+8 → next cycle `out_valid`=0, `stall_req`=0, no result emitted. Reset asserted mid-BUSY → all outputs 0 immediately.
